// File: rtl/ftdi_tx_arbiter.sv
// ftdi_tx_arbiter: round-robin framer of two packet sources into the FTDI TX FIFO.
// Define FTDI_TX_CSUM_EN to append a two's-complement checksum byte to every frame.
module ftdi_tx_arbiter #(
    parameter logic [7:0] pSyncByte = 8'hAA,
    parameter int         pMaxLen   = 64
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [1:0] iReq,
    input  logic [7:0] iLen0,
    input  logic [7:0] iLen1,
    input  logic [7:0] iData0,
    input  logic [7:0] iData1,
    input  logic [1:0] iEmpty,
    output logic [1:0] oRdEn,
    output logic       oWrEn,
    output logic [7:0] oWrData,
    input  logic       iWrFull,
    output logic [1:0] oGnt,
    output logic [1:0] oDone,
    output logic       oBusy,
    output logic       oLenErr
);
    localparam logic [7:0] MAX_LEN = 8'(pMaxLen);

    typedef enum logic [2:0] {
        IDLE, SYNC, ID, LEN, PAYLOAD,
`ifdef FTDI_TX_CSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

`ifdef FTDI_TX_CSUM_EN
    localparam state_t TAIL = CSUM;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d, done_q, done_d;
    logic [7:0] cnt_q, cnt_d, len_q, len_d, len_in;
    logic       len_err_q, len_err_d, ch_q, ch_d, last_q, last_d, sel, xfer;
`ifdef FTDI_TX_CSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    always_comb begin
        sel       = (iReq == 2'b11) ? ~last_q : iReq[1];
        len_in    = sel ? iLen1 : iLen0;
        xfer      = !iWrFull && !iEmpty[ch_q];
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        len_err_d = len_err_q;
        ch_d      = ch_q;
        last_d    = last_q;
        oWrEn     = 1'b0;
        oWrData   = 8'h00;
        oRdEn     = 2'b00;
        case (state_q)
            IDLE: if (|iReq) begin
                ch_d      = sel;
                len_d     = (len_in > MAX_LEN) ? MAX_LEN : len_in;
                len_err_d = len_err_q || (len_in > MAX_LEN);
                gnt_d     = sel ? 2'b10 : 2'b01;
                cnt_d     = 8'd0;
                state_d   = SYNC;
            end
            SYNC: begin
                oWrEn   = !iWrFull;
                oWrData = pSyncByte;
                state_d = oWrEn ? ID : SYNC;
            end
            ID: begin
                oWrEn   = !iWrFull;
                oWrData = {7'b0, ch_q};
                state_d = oWrEn ? LEN : ID;
            end
            LEN: begin
                oWrEn   = !iWrFull;
                oWrData = len_q;
                state_d = !oWrEn ? LEN : (len_q != 8'd0) ? PAYLOAD : TAIL;
            end
            PAYLOAD: begin
                oWrEn   = xfer;
                oRdEn   = xfer ? {ch_q, !ch_q} : 2'b00;
                oWrData = ch_q ? iData1 : iData0;
                cnt_d   = xfer ? cnt_q + 8'd1 : cnt_q;
                state_d = (xfer && cnt_q == len_q - 8'd1) ? TAIL : PAYLOAD;
            end
`ifdef FTDI_TX_CSUM_EN
            CSUM: begin
                oWrEn   = !iWrFull;
                oWrData = 8'd0 - csum_q;
                state_d = oWrEn ? DONE : CSUM;
            end
`endif
            DONE: begin
                gnt_d   = 2'b00;
                last_d  = ch_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef FTDI_TX_CSUM_EN
        csum_d = (state_q == IDLE) ? 8'd0 :
                 (oWrEn && state_q inside {ID, LEN, PAYLOAD}) ? csum_q + oWrData : csum_q;
`endif
        // Pulse while sitting in DONE so the requester can drop iReq before IDLE samples it.
        done_d = (state_d == DONE && state_q != DONE) ? {ch_q, !ch_q} : 2'b00;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            cnt_q     <= 8'd0;
            len_q     <= 8'd0;
            len_err_q <= 1'b0;
            ch_q      <= 1'b0;
            last_q    <= 1'b1;
`ifdef FTDI_TX_CSUM_EN
            csum_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            len_err_q <= len_err_d;
            ch_q      <= ch_d;
            last_q    <= last_d;
`ifdef FTDI_TX_CSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign oGnt    = gnt_q;
    assign oDone   = done_q;
    assign oLenErr = len_err_q;
    assign oBusy   = state_q != IDLE;
endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// tb_ftdi_tx_arbiter: scoreboard bench for ftdi_tx_arbiter with modelled source FIFOs.
module tb_ftdi_tx_arbiter;
`ifdef FTDI_TX_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    logic       iClk = 1'b0, iRst = 1'b1, iWrFull = 1'b0;
    logic [1:0] iReq = 2'b00, iEmpty = 2'b11;
    logic [7:0] iLen0 = 8'd0, iLen1 = 8'd0, iData0 = 8'd0, iData1 = 8'd0;
    logic [1:0] oRdEn, oGnt, oDone;
    logic       oWrEn, oBusy, oLenErr;
    logic [7:0] oWrData;

    ftdi_tx_arbiter dut (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iLen0(iLen0), .iLen1(iLen1),
        .iData0(iData0), .iData1(iData1), .iEmpty(iEmpty), .oRdEn(oRdEn),
        .oWrEn(oWrEn), .oWrData(oWrData), .iWrFull(iWrFull), .oGnt(oGnt),
        .oDone(oDone), .oBusy(oBusy), .oLenErr(oLenErr)
    );

    always #5 iClk = ~iClk;

    int checks = 0, errors = 0;
    int cyc = 0, first_cyc = 0, last_cyc = 0;
    int done0 = 0, done1 = 0, rd0 = 0, rd1 = 0, popped0 = 0, popped1 = 0;
    logic [8:0] exp_q[$];
    logic [7:0] src0[$], src1[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge iClk) begin
        logic [8:0] e;
        cyc++;
        if (oWrEn) begin
            if (exp_q.size() == 0) check("sb_extra_write", {24'd0, oWrData}, 32'hFFFF_FFFF);
            else begin
                e = exp_q.pop_front();
                check("wr_data", {24'd0, oWrData}, {24'd0, e[7:0]});
                if (e[8]) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
        if (|oRdEn) check("rd_gnt_wr", {29'd0, oRdEn & ~oGnt, oWrEn}, 32'd1);
        if (oDone[0]) done0++;
        if (oDone[1]) done1++;
        if (oRdEn[0]) rd0++;
        if (oRdEn[1]) rd1++;
    end

    always @(posedge iClk) begin
        #2;
        while (popped0 < rd0) begin
            if (src0.size() > 0) void'(src0.pop_front());
            popped0++;
        end
        while (popped1 < rd1) begin
            if (src1.size() > 0) void'(src1.pop_front());
            popped1++;
        end
        iData0 = (src0.size() > 0) ? src0[0] : 8'h00;
        iData1 = (src1.size() > 0) ? src1[0] : 8'h00;
        iEmpty = {src1.size() == 0, src0.size() == 0};
    end

    function automatic logic [7:0] dat(input logic [7:0] base, input int i);
        return base + 8'(17 * i);
    endfunction

    task automatic load_src(input int ch, input logic [7:0] base, input int first, input int n);
        for (int i = first; i < first + n; i++)
            if (ch != 0) src1.push_back(dat(base, i));
            else src0.push_back(dat(base, i));
    endtask

    task automatic push_frame(input int ch, input int len, input logic [7:0] base);
        int lc;
`ifdef FTDI_TX_CSUM_EN
        logic [7:0] s;
`endif
        lc = (len > 64) ? 64 : len;
        exp_q.push_back({1'b1, 8'hAA});
        exp_q.push_back({1'b0, 8'(ch)});
        exp_q.push_back({1'b0, 8'(lc)});
        for (int i = 0; i < lc; i++) exp_q.push_back({1'b0, dat(base, i)});
`ifdef FTDI_TX_CSUM_EN
        s = 8'(ch) + 8'(lc);
        for (int i = 0; i < lc; i++) s = s + dat(base, i);
        exp_q.push_back({1'b0, 8'd0 - s});
`endif
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic wait_done(input int ch, input int target);
        int k = 0;
        while (((ch != 0) ? done1 : done0) < target && k < 3000) begin
            tick(1);
            k++;
        end
        check((ch != 0) ? "done1_wait" : "done0_wait", {31'd0, ((ch != 0) ? done1 : done0) >= target}, 32'd1);
    endtask

    task automatic wait_rd(input int ch, input int target);
        int k = 0;
        while (((ch != 0) ? rd1 : rd0) < target && k < 3000) begin
            tick(1);
            k++;
        end
        check((ch != 0) ? "rd1_wait" : "rd0_wait", {31'd0, ((ch != 0) ? rd1 : rd0) >= target}, 32'd1);
    endtask

    initial begin
        int d0, d1, r;
        tick(3);
        check("rst_gnt", {30'd0, oGnt}, 32'd0);
        check("rst_done", {30'd0, oDone}, 32'd0);
        check("rst_lenerr", {31'd0, oLenErr}, 32'd0);
        check("rst_busy", {31'd0, oBusy}, 32'd0);
        check("rst_wren", {31'd0, oWrEn}, 32'd0);
        iRst = 1'b0;
        tick(2);
        check("idle_busy", {31'd0, oBusy}, 32'd0);

        // both requesting from reset: ch0 first, then strict alternation
        iLen0 = 8'd2; iLen1 = 8'd2;
        load_src(0, 8'h40, 0, 2); load_src(0, 8'h50, 0, 2);
        load_src(1, 8'h60, 0, 2); load_src(1, 8'h70, 0, 2);
        push_frame(0, 2, 8'h40); push_frame(1, 2, 8'h60);
        push_frame(0, 2, 8'h50); push_frame(1, 2, 8'h70);
        iReq = 2'b11;
        wait_done(1, 2);
        iReq = 2'b00;
        tick(2);
        check("alt_done0", done0, 32'd2);
        check("alt_sb", exp_q.size(), 32'd0);

        // single ch0 frame, 11 22 33, back-to-back bytes
        d0 = done0;
        iLen0 = 8'd3;
        load_src(0, 8'h11, 0, 3);
        push_frame(0, 3, 8'h11);
        iReq = 2'b01;
        wait_done(0, d0 + 1);
        iReq = 2'b00;
        tick(2);
        check("single_span", last_cyc - first_cyc, 32'(5 + CS));
        check("single_done", done0 - d0, 32'd1);
        check("single_sb", exp_q.size(), 32'd0);
        check("single_busy", {31'd0, oBusy}, 32'd0);

        // TX full for 5 cycles mid-payload
        d0 = done0;
        iLen0 = 8'd6;
        load_src(0, 8'h80, 0, 6);
        push_frame(0, 6, 8'h80);
        iReq = 2'b01;
        wait_rd(0, rd0 + 2);
        iWrFull = 1'b1;
        repeat (5) begin
            #2;
            check("stall_wr", {31'd0, oWrEn}, 32'd0);
            check("stall_rd", {30'd0, oRdEn}, 32'd0);
            check("stall_gnt", {30'd0, oGnt}, 32'd1);
            tick(1);
        end
        iWrFull = 1'b0;
        wait_done(0, d0 + 1);
        iReq = 2'b00;
        tick(2);
        check("stall_sb", exp_q.size(), 32'd0);

        // ch1 source runs dry mid-payload while ch0 also requests
        d0 = done0; d1 = done1;
        iLen1 = 8'd6; iLen0 = 8'd2;
        load_src(1, 8'h90, 0, 2);
        load_src(0, 8'hA0, 0, 2);
        push_frame(1, 6, 8'h90);
        push_frame(0, 2, 8'hA0);
        iReq = 2'b10;
        wait_rd(1, rd1 + 2);
        iReq = 2'b11;
        repeat (5) begin
            tick(1);
            check("empty_gnt", {30'd0, oGnt}, 32'd2);
            check("empty_rd", {30'd0, oRdEn}, 32'd0);
        end
        load_src(1, 8'h90, 2, 4);
        wait_done(1, d1 + 1);
        iReq = 2'b01;
        wait_done(0, d0 + 1);
        iReq = 2'b00;
        tick(2);
        check("empty_sb", exp_q.size(), 32'd0);

        // oversize length clamps to 64, then a zero-length frame
        d0 = done0; r = rd0;
        iLen0 = 8'd200;
        load_src(0, 8'h01, 0, 200);
        push_frame(0, 200, 8'h01);
        iReq = 2'b01;
        wait_done(0, d0 + 1);
        iReq = 2'b00;
        tick(2);
        check("clamp_reads", rd0 - r, 32'd64);
        check("clamp_lenerr", {31'd0, oLenErr}, 32'd1);
        check("clamp_surplus", src0.size(), 32'd136);
        src0.delete();
        tick(1);
        iLen0 = 8'd0;
        push_frame(0, 0, 8'h00);
        iReq = 2'b01;
        wait_done(0, d0 + 2);
        iReq = 2'b00;
        tick(2);
        check("zero_reads", rd0 - r, 32'd64);
        check("zero_lenerr", {31'd0, oLenErr}, 32'd1);
        check("zero_sb", exp_q.size(), 32'd0);

        // reset during ch1 payload
        iLen1 = 8'd10;
        load_src(1, 8'hC0, 0, 10);
        push_frame(1, 10, 8'hC0);
        iReq = 2'b10;
        wait_rd(1, rd1 + 3);
        iRst = 1'b1;
        iReq = 2'b00;
        #1;
        check("arst_wr", {31'd0, oWrEn}, 32'd0);
        check("arst_rd", {30'd0, oRdEn}, 32'd0);
        check("arst_gnt", {30'd0, oGnt}, 32'd0);
        check("arst_busy", {31'd0, oBusy}, 32'd0);
        check("arst_lenerr", {31'd0, oLenErr}, 32'd0);
        tick(2);
        exp_q.delete();
        src1.delete();
        iRst = 1'b0;
        tick(2);
        d0 = done0; d1 = done1;
        iLen0 = 8'd2; iLen1 = 8'd2;
        load_src(0, 8'hD0, 0, 2);
        load_src(1, 8'hE0, 0, 2);
        push_frame(0, 2, 8'hD0);
        push_frame(1, 2, 8'hE0);
        iReq = 2'b11;
        wait_done(0, d0 + 1);
        wait_done(1, d1 + 1);
        iReq = 2'b00;
        tick(2);
        check("post_rst_sb", exp_q.size(), 32'd0);
        check("post_rst_done", (done0 - d0) + (done1 - d1), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
